// File: rtl/instr_decode_pipe_pkg.sv
// Shared opcode map, decode classes and function codes for the 9-bit CPU decode stage.
package instr_decode_pipe_pkg;

   typedef enum logic [3:0] {
      CLS_VAL     = 4'd0,
      CLS_MOV     = 4'd1,
      CLS_MEM     = 4'd2,
      CLS_INCDEC  = 4'd3,
      CLS_BRANCH  = 4'd4,
      CLS_JTSR    = 4'd5,
      CLS_MATH    = 4'd6,
      CLS_SHIFT   = 4'd7,
      CLS_FLIP    = 4'd8,
      CLS_FUNC    = 4'd9,
      CLS_ILLEGAL = 4'd10
   } dec_cls_t;

   localparam logic [4:0] OP_VALL   = 5'b00000;
   localparam logic [4:0] OP_VALH   = 5'b00001;
   localparam logic [4:0] OP_LOAD   = 5'b10000;
   localparam logic [4:0] OP_STOR   = 5'b10001;
   localparam logic [4:0] OP_INCR   = 5'b10010;
   localparam logic [4:0] OP_DECR   = 5'b10011;
   localparam logic [4:0] OP_JIZR   = 5'b10100;
   localparam logic [4:0] OP_JNZR   = 5'b10101;
   localparam logic [4:0] OP_BIZR   = 5'b10110;
   localparam logic [4:0] OP_BNZR   = 5'b10111;
   localparam logic [4:0] OP_JTSR   = 5'b11000;
   localparam logic [4:0] OP_UNUSED = 5'b11001;
   localparam logic [4:0] OP_MTHR   = 5'b11010;
   localparam logic [4:0] OP_MTHS   = 5'b11011;
   localparam logic [4:0] OP_LSLC   = 5'b11100;
   localparam logic [4:0] OP_LSRC   = 5'b11101;
   localparam logic [4:0] OP_FLIP   = 5'b11110;
   localparam logic [4:0] OP_FUNC   = 5'b11111;

   localparam logic [3:0] FN_DONE   = 4'hF;

   function automatic logic is_halt_op(input logic [4:0] opc, input logic [3:0] fn);
      return (opc == OP_FUNC) && (fn == FN_DONE);
   endfunction

endpackage

// File: rtl/instr_decode_pipe_if.sv
// Fetch-side instruction stream and consumer-side decoded bundle stream of the decode stage.
interface instr_decode_pipe_if #(
   parameter int ARG_W   = 4,
   parameter int MAX_PFX = 3
) ();
   import instr_decode_pipe_pkg::*;

   localparam int IMM_W = ARG_W * (MAX_PFX + 1);
   localparam int CNT_W = $clog2(MAX_PFX + 1);

   logic             instr_valid;
   logic             instr_ready;
   logic [ARG_W+4:0] instr;

   logic             dec_valid;
   logic             dec_ready;
   dec_cls_t         dec_cls;
   logic [4:0]       dec_opc;
   logic [3:0]       dec_reg;
   logic [3:0]       dec_math;
   logic             dec_sel;
   logic [IMM_W-1:0] dec_imm;
   logic [CNT_W-1:0] dec_pfx_cnt;
   logic             dec_illegal;

   modport master (
      output instr_valid, instr, dec_ready,
      input  instr_ready, dec_valid, dec_cls, dec_opc, dec_reg, dec_math,
             dec_sel, dec_imm, dec_pfx_cnt, dec_illegal
   );

   modport slave (
      input  instr_valid, instr, dec_ready,
      output instr_ready, dec_valid, dec_cls, dec_opc, dec_reg, dec_math,
             dec_sel, dec_imm, dec_pfx_cnt, dec_illegal
   );

endinterface

// File: rtl/instr_decode_pipe_classify.sv
// Combinational opcode classifier: opcode plus low operand nibble to decode class and fields.
module instr_classify
   import instr_decode_pipe_pkg::*;
(
   input  logic [4:0] opc_i,
   input  logic [3:0] arg_i,
   output dec_cls_t   cls_o,
   output logic [3:0] reg_o,
   output logic [3:0] math_o,
   output logic       sel_o,
   output logic       illegal_o
);

   always_comb begin
      cls_o     = CLS_ILLEGAL;
      reg_o     = 4'd0;
      math_o    = 4'd0;
      sel_o     = 1'b0;
      illegal_o = 1'b0;
      case (opc_i)
         OP_VALL: begin
            cls_o = CLS_VAL;
            reg_o = arg_i;
         end
         // a prefix only reaches here when the prefix chain overflows
         OP_VALH, OP_UNUSED: illegal_o = 1'b1;
         OP_LOAD, OP_STOR: begin
            cls_o = CLS_MEM;
            reg_o = arg_i;
            sel_o = opc_i[0];
         end
         OP_INCR, OP_DECR: begin
            cls_o = CLS_INCDEC;
            reg_o = arg_i;
         end
         OP_JIZR, OP_JNZR, OP_BIZR, OP_BNZR: begin
            cls_o = CLS_BRANCH;
            reg_o = arg_i;
         end
         OP_JTSR: cls_o = CLS_JTSR;
         OP_MTHR, OP_MTHS: begin
            cls_o  = CLS_MATH;
            math_o = arg_i;
            sel_o  = opc_i[0];
         end
         OP_LSLC, OP_LSRC: cls_o = CLS_SHIFT;
         OP_FLIP:          cls_o = CLS_FLIP;
         OP_FUNC:          cls_o = CLS_FUNC;
         // everything left is 00010-01111, the register-move block
         default: begin
            cls_o = CLS_MOV;
            reg_o = opc_i[3:0];
         end
      endcase
   end

endmodule

// File: rtl/instr_decode_pipe.sv
// Registered decode stage: valh prefix accumulation, one-deep output register, halt and flush control.
module instr_decode_pipe
   import instr_decode_pipe_pkg::*;
#(
   parameter int ARG_W   = 4,
   parameter int MAX_PFX = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 resume,
   instr_decode_pipe_if.slave   bus,
   output logic                 halted,
   output logic                 pfx_pending
);

   localparam int IMM_W = ARG_W * (MAX_PFX + 1);
   localparam int CNT_W = $clog2(MAX_PFX + 1);
   localparam int ACC_W = ARG_W * MAX_PFX;

   logic [4:0]       opc;
   logic [ARG_W-1:0] arg;
   logic             accept;
   logic             pfx_take;
   logic             emit;

   dec_cls_t         cls_c;
   logic [3:0]       reg_c;
   logic [3:0]       math_c;
   logic             sel_c;
   logic             illegal_c;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             halted_q, halted_d;

   logic             dec_valid_q;
   dec_cls_t         dec_cls_q;
   logic [4:0]       dec_opc_q;
   logic [3:0]       dec_reg_q;
   logic [3:0]       dec_math_q;
   logic             dec_sel_q;
   logic [IMM_W-1:0] dec_imm_q;
   logic [CNT_W-1:0] dec_pfx_cnt_q;
   logic             dec_illegal_q;

   assign opc = bus.instr[ARG_W+4:ARG_W];
   assign arg = bus.instr[ARG_W-1:0];

   assign bus.instr_ready = !reset && !flush && !halted_q && (!dec_valid_q || bus.dec_ready);
   assign accept          = bus.instr_valid && bus.instr_ready;
   assign pfx_take        = accept && (opc == OP_VALH) && (cnt_q < CNT_W'(MAX_PFX));
   assign emit            = accept && !pfx_take;

   instr_classify u_classify (
      .opc_i     (opc),
      .arg_i     (arg[3:0]),
      .cls_o     (cls_c),
      .reg_o     (reg_c),
      .math_o    (math_c),
      .sel_o     (sel_c),
      .illegal_o (illegal_c)
   );

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (flush || emit) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (pfx_take) begin
         acc_d = (acc_q << ARG_W) | ACC_W'(arg);
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // a done accepted alongside a resume still halts: it is the newer event
   always_comb begin
      halted_d = resume ? 1'b0 : halted_q;
      if (accept && is_halt_op(opc, arg[3:0]))
         halted_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q         <= '0;
         cnt_q         <= '0;
         halted_q      <= 1'b0;
         dec_valid_q   <= 1'b0;
         dec_cls_q     <= CLS_VAL;
         dec_opc_q     <= '0;
         dec_reg_q     <= '0;
         dec_math_q    <= '0;
         dec_sel_q     <= 1'b0;
         dec_imm_q     <= '0;
         dec_pfx_cnt_q <= '0;
         dec_illegal_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         halted_q <= halted_d;
         if (flush) begin
            dec_valid_q <= 1'b0;
         end else if (emit) begin
            dec_valid_q   <= 1'b1;
            dec_cls_q     <= cls_c;
            dec_opc_q     <= opc;
            dec_reg_q     <= reg_c;
            dec_math_q    <= math_c;
            dec_sel_q     <= sel_c;
            dec_imm_q     <= {acc_q, arg};
            dec_pfx_cnt_q <= cnt_q;
            dec_illegal_q <= illegal_c;
         end else if (bus.dec_ready) begin
            dec_valid_q <= 1'b0;
         end
      end
   end

   assign bus.dec_valid   = dec_valid_q;
   assign bus.dec_cls     = dec_cls_q;
   assign bus.dec_opc     = dec_opc_q;
   assign bus.dec_reg     = dec_reg_q;
   assign bus.dec_math    = dec_math_q;
   assign bus.dec_sel     = dec_sel_q;
   assign bus.dec_imm     = dec_imm_q;
   assign bus.dec_pfx_cnt = dec_pfx_cnt_q;
   assign bus.dec_illegal = dec_illegal_q;

   assign halted      = halted_q;
   assign pfx_pending = (cnt_q != '0);

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Self-checking bench: opcode table, directed multi-cycle sequences, then random traffic against a queue-based model.
module tb_instr_decode_pipe;
   import instr_decode_pipe_pkg::*;

   localparam int ARG_W   = 4;
   localparam int MAX_PFX = 3;
   localparam int N_RAND  = 3000;

   logic clk = 1'b0;
   logic reset, flush, resume, halted, pfx_pending;

   always #5 clk = ~clk;

   instr_decode_pipe_if #(.ARG_W(ARG_W), .MAX_PFX(MAX_PFX)) bus ();

   instr_decode_pipe #(.ARG_W(ARG_W), .MAX_PFX(MAX_PFX)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .resume      (resume),
      .bus         (bus.slave),
      .halted      (halted),
      .pfx_pending (pfx_pending)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [4:0] o, input logic [3:0] a);
      bus.instr_valid = 1'b1;
      bus.instr       = {o, a};
   endtask

   task automatic chk_bundle(input string nm, input dec_cls_t cls, input logic [3:0] rg,
                             input logic [15:0] imm, input int cnt);
      chk({nm, "_valid"}, bus.dec_valid, 1'b1);
      chk({nm, "_cls"},   bus.dec_cls, cls);
      chk({nm, "_reg"},   bus.dec_reg, rg);
      chk({nm, "_imm"},   bus.dec_imm, imm);
      chk({nm, "_cnt"},   bus.dec_pfx_cnt, cnt);
   endtask

   typedef struct {
      logic [4:0] opc;
      logic [3:0] arg;
      dec_cls_t   cls;
      logic [3:0] rg;
      logic       chk_rg;
      logic [3:0] math;
      logic       sel;
      logic       ill;
   } vec_t;

   vec_t tbl[$];

   // reference model state: pending prefix chunks in arrival order, one output slot
   typedef struct {
      dec_cls_t    cls;
      logic [4:0]  opc;
      logic [3:0]  rg;
      logic        chk_rg;
      logic [3:0]  math;
      logic        sel;
      logic        ill;
      logic [15:0] imm;
      int          cnt;
      logic        chk_imm;
   } bund_t;

   int unsigned m_pfx[$];
   logic        m_ovalid = 1'b0;
   logic        m_halted = 1'b0;
   bund_t       m_b;

   function automatic bund_t ref_class(input logic [4:0] o, input logic [3:0] a);
      bund_t b;
      int    n;
      n         = int'(o);
      b.opc     = o;
      b.rg      = a;
      b.chk_rg  = 1'b1;
      b.math    = 4'd0;
      b.sel     = 1'b0;
      b.ill     = 1'b0;
      b.imm     = 16'd0;
      b.cnt     = 0;
      b.chk_imm = 1'b1;
      b.cls     = CLS_ILLEGAL;
      if (n == 0)                 b.cls = CLS_VAL;
      else if (n >= 2 && n <= 15) begin b.cls = CLS_MOV; b.rg = o[3:0]; end
      else if (n == 1 || n == 25) begin b.ill = 1'b1; b.chk_rg = 1'b0; end
      else if (n == 16 || n == 17) begin b.cls = CLS_MEM; b.sel = (n == 17); end
      else if (n == 18 || n == 19) b.cls = CLS_INCDEC;
      else if (n >= 20 && n <= 23) b.cls = CLS_BRANCH;
      else if (n == 24)           begin b.cls = CLS_JTSR; b.chk_rg = 1'b0; end
      else if (n == 26 || n == 27) begin
         b.cls = CLS_MATH; b.math = a; b.sel = (n == 27); b.chk_rg = 1'b0;
      end
      else if (n == 28 || n == 29) begin b.cls = CLS_SHIFT; b.chk_rg = 1'b0; end
      else if (n == 30)           begin b.cls = CLS_FLIP;  b.chk_rg = 1'b0; end
      else                        begin b.cls = CLS_FUNC;  b.chk_rg = 1'b0; end
      return b;
   endfunction

   task automatic model_step(input logic rst, input logic fl, input logic rs, input logic iv,
                             input logic dr, input logic [8:0] ins);
      logic rdy, acc;
      logic [4:0] o;
      logic [3:0] a;
      int unsigned imm;
      if (rst) begin
         m_ovalid = 1'b0;
         m_halted = 1'b0;
         m_pfx.delete();
         return;
      end
      o   = ins[8:4];
      a   = ins[3:0];
      rdy = !fl && !m_halted && (!m_ovalid || dr);
      acc = iv && rdy;
      if (rs) m_halted = 1'b0;
      if (acc && o == 5'b11111 && a == 4'hF) m_halted = 1'b1;
      if (fl) begin
         m_ovalid = 1'b0;
         m_pfx.delete();
      end else begin
         if (m_ovalid && dr) m_ovalid = 1'b0;
         if (acc) begin
            if (o == 5'b00001 && m_pfx.size() < MAX_PFX) begin
               m_pfx.push_back(a);
            end else if (o == 5'b00001) begin
               m_b         = ref_class(o, a);
               m_b.chk_imm = 1'b0;
               m_ovalid    = 1'b1;
               m_pfx.delete();
            end else begin
               m_b = ref_class(o, a);
               imm = 0;
               foreach (m_pfx[k]) imm = imm * (1 << ARG_W) + m_pfx[k];
               imm       = imm * (1 << ARG_W) + a;
               m_b.imm   = imm[15:0];
               m_b.cnt   = m_pfx.size();
               m_ovalid  = 1'b1;
               m_pfx.delete();
            end
         end
      end
   endtask

   initial begin
      logic [4:0] ro;
      logic [3:0] ra;
      logic       rrst, rfl, rrs, riv, rdr, exp_rdy;

      tbl.push_back('{5'b00000, 4'd4, CLS_VAL,     4'd4,  1'b1, 4'd0, 1'b0, 1'b0});
      tbl.push_back('{5'b01111, 4'd1, CLS_MOV,     4'd15, 1'b1, 4'd0, 1'b0, 1'b0});
      tbl.push_back('{5'b10000, 4'd3, CLS_MEM,     4'd3,  1'b1, 4'd0, 1'b0, 1'b0});
      tbl.push_back('{5'b10001, 4'd6, CLS_MEM,     4'd6,  1'b1, 4'd0, 1'b1, 1'b0});
      tbl.push_back('{5'b10010, 4'd7, CLS_INCDEC,  4'd7,  1'b1, 4'd0, 1'b0, 1'b0});
      tbl.push_back('{5'b10011, 4'd8, CLS_INCDEC,  4'd8,  1'b1, 4'd0, 1'b0, 1'b0});
      tbl.push_back('{5'b10100, 4'd1, CLS_BRANCH,  4'd1,  1'b1, 4'd0, 1'b0, 1'b0});
      tbl.push_back('{5'b10111, 4'd2, CLS_BRANCH,  4'd2,  1'b1, 4'd0, 1'b0, 1'b0});
      tbl.push_back('{5'b11000, 4'd0, CLS_JTSR,    4'd0,  1'b0, 4'd0, 1'b0, 1'b0});
      tbl.push_back('{5'b11010, 4'd9, CLS_MATH,    4'd0,  1'b0, 4'd9, 1'b0, 1'b0});
      tbl.push_back('{5'b11011, 4'd5, CLS_MATH,    4'd0,  1'b0, 4'd5, 1'b1, 1'b0});
      tbl.push_back('{5'b11100, 4'd2, CLS_SHIFT,   4'd0,  1'b0, 4'd0, 1'b0, 1'b0});
      tbl.push_back('{5'b11101, 4'd2, CLS_SHIFT,   4'd0,  1'b0, 4'd0, 1'b0, 1'b0});
      tbl.push_back('{5'b11110, 4'd0, CLS_FLIP,    4'd0,  1'b0, 4'd0, 1'b0, 1'b0});
      tbl.push_back('{5'b11111, 4'd3, CLS_FUNC,    4'd0,  1'b0, 4'd0, 1'b0, 1'b0});
      tbl.push_back('{5'b11001, 4'hC, CLS_ILLEGAL, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1});

      reset = 1'b1; flush = 1'b0; resume = 1'b0;
      bus.instr_valid = 1'b0; bus.instr = '0; bus.dec_ready = 1'b1;
      cyc(); cyc();
      chk("rst_ready",   bus.instr_ready, 1'b0);
      chk("rst_valid",   bus.dec_valid, 1'b0);
      chk("rst_halted",  halted, 1'b0);
      chk("rst_pending", pfx_pending, 1'b0);
      chk("rst_imm",     bus.dec_imm, 16'd0);
      reset = 1'b0;
      #1 chk("ready_after_rst", bus.instr_ready, 1'b1);

      // movc arg 5
      drive(5'b00010, 4'd5);
      cyc();
      bus.instr_valid = 1'b0;
      chk_bundle("movc", CLS_MOV, 4'd2, 16'd5, 0);
      cyc();
      chk("movc_retire", bus.dec_valid, 1'b0);

      foreach (tbl[i]) begin
         drive(tbl[i].opc, tbl[i].arg);
         cyc();
         bus.instr_valid = 1'b0;
         chk($sformatf("tbl%0d_valid", i), bus.dec_valid, 1'b1);
         chk($sformatf("tbl%0d_cls", i),   bus.dec_cls, tbl[i].cls);
         chk($sformatf("tbl%0d_opc", i),   bus.dec_opc, tbl[i].opc);
         if (tbl[i].chk_rg) chk($sformatf("tbl%0d_reg", i), bus.dec_reg, tbl[i].rg);
         chk($sformatf("tbl%0d_math", i),  bus.dec_math, tbl[i].math);
         chk($sformatf("tbl%0d_sel", i),   bus.dec_sel, tbl[i].sel);
         chk($sformatf("tbl%0d_ill", i),   bus.dec_illegal, tbl[i].ill);
         chk($sformatf("tbl%0d_imm", i),   bus.dec_imm, {12'd0, tbl[i].arg});
         chk($sformatf("tbl%0d_cnt", i),   bus.dec_pfx_cnt, 2'd0);
         cyc();
      end

      // two prefixes then vall
      drive(5'b00001, 4'h3);
      cyc();
      chk("pfx1_valid", bus.dec_valid, 1'b0);
      chk("pfx1_pending", pfx_pending, 1'b1);
      drive(5'b00001, 4'hA);
      cyc();
      chk("pfx2_valid", bus.dec_valid, 1'b0);
      drive(5'b00000, 4'h7);
      cyc();
      bus.instr_valid = 1'b0;
      chk_bundle("pfx_vall", CLS_VAL, 4'h7, 16'h03A7, 2);
      chk("pfx_vall_pending", pfx_pending, 1'b0);
      cyc();
      chk("pfx_vall_once", bus.dec_valid, 1'b0);

      // prefix overflow
      for (int k = 1; k <= 4; k++) begin
         drive(5'b00001, 4'(k));
         cyc();
      end
      chk("ovf_valid", bus.dec_valid, 1'b1);
      chk("ovf_cls", bus.dec_cls, CLS_ILLEGAL);
      chk("ovf_ill", bus.dec_illegal, 1'b1);
      chk("ovf_pending", pfx_pending, 1'b0);
      drive(5'b00000, 4'h5);
      cyc();
      bus.instr_valid = 1'b0;
      chk_bundle("ovf_vall", CLS_VAL, 4'h5, 16'h0005, 0);
      chk("ovf_vall_ill", bus.dec_illegal, 1'b0);
      cyc();

      // back-pressure with a stream of incr
      bus.dec_ready = 1'b0;
      drive(5'b10010, 4'd1);
      cyc();
      drive(5'b10010, 4'd2);
      for (int k = 0; k < 3; k++) begin
         #1 chk("stall_ready", bus.instr_ready, 1'b0);
         chk("stall_valid", bus.dec_valid, 1'b1);
         chk("stall_reg", bus.dec_reg, 4'd1);
         cyc();
      end
      bus.dec_ready = 1'b1;
      #1 chk("release_ready", bus.instr_ready, 1'b1);
      cyc();
      chk_bundle("release2", CLS_INCDEC, 4'd2, 16'd2, 0);
      drive(5'b10010, 4'd3);
      cyc();
      bus.instr_valid = 1'b0;
      chk_bundle("release3", CLS_INCDEC, 4'd3, 16'd3, 0);
      cyc();
      chk("release_drain", bus.dec_valid, 1'b0);

      // func done halts, resume releases
      drive(5'b11111, 4'hF);
      cyc();
      chk("done_valid", bus.dec_valid, 1'b1);
      chk("done_cls", bus.dec_cls, CLS_FUNC);
      chk("done_halted", halted, 1'b1);
      drive(5'b00000, 4'h1);
      #1 chk("halt_ready", bus.instr_ready, 1'b0);
      cyc();
      chk("halt_nolaunch", bus.dec_valid, 1'b0);
      chk("halt_sticky", halted, 1'b1);
      resume = 1'b1;
      cyc();
      resume = 1'b0;
      chk("resume_halted", halted, 1'b0);
      #1 chk("resume_ready", bus.instr_ready, 1'b1);
      cyc();
      bus.instr_valid = 1'b0;
      chk_bundle("resume_vall", CLS_VAL, 4'h1, 16'h0001, 0);
      cyc();

      // flush drops a pending prefix
      drive(5'b00001, 4'h1);
      cyc();
      chk("flush_pfx_pending", pfx_pending, 1'b1);
      drive(5'b00000, 4'h3);
      flush = 1'b1;
      #1 chk("flush_ready", bus.instr_ready, 1'b0);
      cyc();
      flush = 1'b0;
      bus.instr_valid = 1'b0;
      chk("flush_pending", pfx_pending, 1'b0);
      chk("flush_valid", bus.dec_valid, 1'b0);
      drive(5'b11010, 4'h9);
      cyc();
      bus.instr_valid = 1'b0;
      chk_bundle("flush_mthr", CLS_MATH, bus.dec_reg, 16'h0009, 0);
      chk("flush_mthr_math", bus.dec_math, 4'h9);
      chk("flush_mthr_sel", bus.dec_sel, 1'b0);
      cyc();

      // flush drops a held output bundle
      bus.dec_ready = 1'b0;
      drive(5'b10010, 4'd4);
      cyc();
      bus.instr_valid = 1'b0;
      chk("flushout_valid", bus.dec_valid, 1'b1);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      bus.dec_ready = 1'b1;
      chk("flushout_cleared", bus.dec_valid, 1'b0);

      // reset mid-prefix
      drive(5'b00001, 4'h5);
      cyc();
      bus.instr_valid = 1'b0;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rstmid_pending", pfx_pending, 1'b0);
      chk("rstmid_valid", bus.dec_valid, 1'b0);
      drive(5'b00000, 4'h1);
      cyc();
      bus.instr_valid = 1'b0;
      chk_bundle("rstmid_vall", CLS_VAL, 4'h1, 16'h0001, 0);
      cyc();

      // random traffic against the model
      for (int i = 0; i < N_RAND; i++) begin
         if (i > 0) begin
            chk("rnd_valid", bus.dec_valid, m_ovalid);
            chk("rnd_halted", halted, m_halted);
            chk("rnd_pending", pfx_pending, m_pfx.size() != 0);
            if (m_ovalid) begin
               chk("rnd_cls",  bus.dec_cls, m_b.cls);
               chk("rnd_opc",  bus.dec_opc, m_b.opc);
               chk("rnd_math", bus.dec_math, m_b.math);
               chk("rnd_sel",  bus.dec_sel, m_b.sel);
               chk("rnd_ill",  bus.dec_illegal, m_b.ill);
               if (m_b.chk_rg) chk("rnd_reg", bus.dec_reg, m_b.rg);
               if (m_b.chk_imm) begin
                  chk("rnd_imm", bus.dec_imm, m_b.imm);
                  chk("rnd_cnt", bus.dec_pfx_cnt, m_b.cnt);
               end
            end
         end
         rrst = (i == 0) || ($urandom_range(0, 149) == 0);
         rfl  = ($urandom_range(0, 29) == 0);
         rrs  = ($urandom_range(0, 7) == 0);
         riv  = ($urandom_range(0, 9) < 7);
         rdr  = ($urandom_range(0, 9) < 7);
         ro   = ($urandom_range(0, 3) == 0) ? 5'b00001 : 5'($urandom_range(0, 31));
         ra   = 4'($urandom_range(0, 15));
         reset = rrst; flush = rfl; resume = rrs;
         bus.instr_valid = riv; bus.dec_ready = rdr; bus.instr = {ro, ra};
         exp_rdy = !rrst && !rfl && !m_halted && (!m_ovalid || rdr);
         #1 chk("rnd_ready", bus.instr_ready, exp_rdy);
         model_step(rrst, rfl, rrs, riv, rdr, {ro, ra});
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
